// File: rtl/recv_all.sv
// recv_all: interboard receiver; six 6-bit words over a 4-phase req/ack handshake form one game-control message.
// Optional: define RECV_TIMEOUT_EN to abort a partial message after TIMEOUT_CYCLES of inter-word gap.
module recv_all #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       msg_valid,
  output logic [3:0] msg_type,
  output logic [4:0] block_x,
  output logic [2:0] block_y,
  output logic [5:0] card,
  output logic [2:0] sel_len,
  output logic       move_dir,
  output logic       msg_err
);

  typedef enum logic [1:0] {
    WAIT_REQ_UP,
    ACK_HIGH,
    WORD_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   clr;
  logic [2:0]             word_idx;

  logic [3:0] sh_type;
  logic [4:0] sh_x;
  logic [2:0] sh_y;
  logic [5:0] sh_card;
  logic [2:0] sh_len;
  logic       sh_dir;

  assign clr   = rst | interboard_rst;
  assign req_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Request_in};
    end
  end

`ifdef RECV_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap;
`else
  assign msg_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= WAIT_REQ_UP;
      word_idx  <= '0;
      Ack_out   <= 1'b0;
      msg_valid <= 1'b0;
      msg_type  <= '0;
      block_x   <= '0;
      block_y   <= '0;
      card      <= '0;
      sel_len   <= '0;
      move_dir  <= 1'b0;
      sh_type   <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_card   <= '0;
      sh_len    <= '0;
      sh_dir    <= 1'b0;
`ifdef RECV_TIMEOUT_EN
      gap       <= '0;
      msg_err   <= 1'b0;
`endif
    end else begin
      msg_valid <= 1'b0;
`ifdef RECV_TIMEOUT_EN
      msg_err   <= 1'b0;
`endif
      unique case (state)
        WAIT_REQ_UP: begin
          if (req_s) begin
            // data is held stable by the sender well before req_s rises
            unique case (word_idx)
              3'd0:    sh_type <= inter_data_in[3:0];
              3'd1:    sh_x    <= inter_data_in[4:0];
              3'd2:    sh_y    <= inter_data_in[2:0];
              3'd3:    sh_card <= inter_data_in;
              3'd4:    sh_len  <= inter_data_in[2:0];
              default: sh_dir  <= inter_data_in[0];
            endcase
            Ack_out <= 1'b1;
            state   <= ACK_HIGH;
          end
`ifdef RECV_TIMEOUT_EN
          else if (word_idx != 3'd0) begin
            if (gap == GW'(TIMEOUT_CYCLES - 1)) begin
              word_idx <= '0;
              gap      <= '0;
              msg_err  <= 1'b1;
            end else begin
              gap <= gap + 1'b1;
            end
          end
`endif
        end
        ACK_HIGH: begin
          if (!req_s) begin
            state <= WORD_DONE;
          end
        end
        WORD_DONE: begin
          Ack_out <= 1'b0;
          state   <= WAIT_REQ_UP;
`ifdef RECV_TIMEOUT_EN
          gap     <= '0;
`endif
          if (word_idx == 3'd5) begin
            word_idx  <= '0;
            msg_valid <= 1'b1;
            msg_type  <= sh_type;
            block_x   <= sh_x;
            block_y   <= sh_y;
            card      <= sh_card;
            sel_len   <= sh_len;
            move_dir  <= sh_dir;
          end else begin
            word_idx <= word_idx + 3'd1;
          end
        end
        default: state <= WAIT_REQ_UP;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_all.sv
// tb_recv_all: drives the 4-phase sender side of recv_all and checks
// latencies and decoded messages against a field-extraction model.
module tb_recv_all;

  logic       clk = 1'b0;
  logic       rst;
  logic       interboard_rst;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       msg_valid;
  logic [3:0] msg_type;
  logic [4:0] block_x;
  logic [2:0] block_y;
  logic [5:0] card;
  logic [2:0] sel_len;
  logic       move_dir;
  logic       msg_err;

  recv_all #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .interboard_rst(interboard_rst),
    .Request_in    (Request_in),
    .inter_data_in (inter_data_in),
    .Ack_out       (Ack_out),
    .msg_valid     (msg_valid),
    .msg_type      (msg_type),
    .block_x       (block_x),
    .block_y       (block_y),
    .card          (card),
    .sel_len       (sel_len),
    .move_dir      (move_dir),
    .msg_err       (msg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] t;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c;
    logic [2:0] s;
    logic       d;
  } msg_t;

  typedef logic [5:0] word_arr_t [6];

  int   vectors = 0;
  int   errors  = 0;
  int   err_pulses = 0;
  int   exp_err = 0;
  msg_t got[$];

  function automatic msg_t cur();
    return {msg_type, block_x, block_y, card, sel_len, move_dir};
  endfunction

  // each field keeps only the low bits of its word
  function automatic msg_t model(input word_arr_t w);
    msg_t m;
    m.t = 4'(w[0] % 16);
    m.x = 5'(w[1] % 32);
    m.y = 3'(w[2] % 8);
    m.c = w[3];
    m.s = 3'(w[4] % 8);
    m.d = 1'(w[5] % 2);
    return m;
  endfunction

  always @(posedge clk) begin
    #1;
    if (msg_valid === 1'b1) got.push_back(cur());
    if (msg_err === 1'b1) err_pulses++;
  end

  task automatic send_word(input logic [5:0] d, input bit last, input int hold);
    int n;
    bit bad;
    @(negedge clk);
    inter_data_in = d;
    Request_in    = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (Ack_out !== 1'b1 && n < 40);
    vectors++;
    if (n != 3) begin
      errors++;
      $display("FAIL ack_rise: %0d edges, expected 3", n);
    end
    if (hold > 0) begin
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (Ack_out !== 1'b1) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
        errors++;
        $display("FAIL ack_hold: Ack_out dropped, expected high for %0d cycles", hold);
      end
    end
    @(negedge clk);
    Request_in = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (Ack_out !== 1'b0 && n < 40);
    vectors++;
    if (n != 4) begin
      errors++;
      $display("FAIL ack_fall: %0d edges, expected 4", n);
    end
    vectors++;
    if (msg_valid !== last) begin
      errors++;
      $display("FAIL valid_edge: msg_valid=%b, expected %b", msg_valid, last);
    end
    inter_data_in = 6'($urandom);
  endtask

  task automatic rand_words(output word_arr_t w);
    for (int i = 0; i < 6; i++) w[i] = 6'($urandom_range(0, 63));
  endtask

  task automatic test_reset();
    rst = 1'b1; interboard_rst = 1'b0;
    Request_in = 1'b0; inter_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({Ack_out, msg_valid, msg_err, cur()} !== '0) begin
      errors++;
      $display("FAIL reset: got %h, expected 0", {Ack_out, msg_valid, msg_err, cur()});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed(input word_arr_t w, input string name);
    msg_t m;
    for (int i = 0; i < 6; i++) send_word(w[i], i == 5, 0);
    vectors++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL %s_count: %0d pulses, expected 1", name, got.size());
    end
    if (got.size() > 0) begin
      m = got.pop_front();
      vectors++;
      if (m !== model(w)) begin
        errors++;
        $display("FAIL %s_fields: got %h, expected %h", name, m, model(w));
      end
    end
    got.delete();
  endtask

  task automatic test_random();
    word_arr_t w;
    msg_t      m;
    for (int k = 0; k < 8; k++) begin
      rand_words(w);
      for (int i = 0; i < 6; i++) send_word(w[i], i == 5, 0);
      vectors++;
      if (got.size() != 1) begin
        errors++;
        $display("FAIL rand_count[%0d]: %0d pulses, expected 1", k, got.size());
      end else begin
        m = got.pop_front();
        vectors++;
        if (m !== model(w)) begin
          errors++;
          $display("FAIL rand_fields[%0d]: got %h, expected %h", k, m, model(w));
        end
      end
      got.delete();
    end
  endtask

  task automatic test_back_to_back();
    word_arr_t w1;
    word_arr_t w2;
    rand_words(w1);
    w1[0] = 6'h31;
    w2 = '{default: 6'h00};
    for (int i = 0; i < 6; i++) send_word(w1[i], i == 5, 0);
    for (int i = 0; i < 5; i++) send_word(w2[i], 1'b0, 0);
    vectors++;
    if (cur() !== model(w1)) begin
      errors++;
      $display("FAIL b2b_hold: got %h, expected %h", cur(), model(w1));
    end
    send_word(w2[5], 1'b1, 0);
    vectors++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d pulses, expected 2", got.size());
    end
    vectors++;
    if (cur() !== '0) begin
      errors++;
      $display("FAIL b2b_zero: got %h, expected 0", cur());
    end
    got.delete();
  endtask

  task automatic test_abort();
    word_arr_t w;
    msg_t      m;
    int        n;
    rand_words(w);
    for (int i = 0; i < 4; i++) send_word(w[i], 1'b0, 0);
    @(negedge clk);
    interboard_rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({Ack_out, msg_valid, cur()} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got %h, expected 0", {Ack_out, msg_valid, cur()});
    end
    @(negedge clk);
    interboard_rst = 1'b0;
    // reset while Ack is high, with Request still high at release
    rand_words(w);
    Request_in = 1'b1;
    inter_data_in = w[0];
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (Ack_out !== 1'b1 && n < 40);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (Ack_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_ack: Ack_out=%b, expected 0", Ack_out);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (Ack_out !== 1'b1 && n < 40);
    vectors++;
    if (n != 3) begin
      errors++;
      $display("FAIL release_word0: %0d edges, expected 3", n);
    end
    @(negedge clk);
    Request_in = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (Ack_out !== 1'b0 && n < 40);
    for (int i = 1; i < 6; i++) send_word(w[i], i == 5, 0);
    vectors++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL abort_count: %0d pulses, expected 1", got.size());
    end else begin
      m = got.pop_front();
      vectors++;
      if (m !== model(w)) begin
        errors++;
        $display("FAIL abort_fields: got %h, expected %h", m, model(w));
      end
    end
    got.delete();
  endtask

  task automatic test_hold();
    word_arr_t w;
    msg_t      m;
    rand_words(w);
    for (int i = 0; i < 6; i++) send_word(w[i], i == 5, (i == 2) ? 50 : 0);
    vectors++;
    if (got.size() != 1) begin
      errors++;
      $display("FAIL hold_count: %0d pulses, expected 1", got.size());
    end else begin
      m = got.pop_front();
      vectors++;
      if (m !== model(w)) begin
        errors++;
        $display("FAIL hold_fields: got %h, expected %h", m, model(w));
      end
    end
    got.delete();
  endtask

`ifdef RECV_TIMEOUT_EN
  task automatic test_timeout();
    word_arr_t w;
    msg_t      before;
    int        n;
    rand_words(w);
    before = cur();
    send_word(w[0], 1'b0, 0);
    send_word(w[1], 1'b0, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (msg_err !== 1'b1 && n < 40);
    exp_err++;
    vectors++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_at: %0d cycles, expected 16", n);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (got.size() != 0 || cur() !== before) begin
      errors++;
      $display("FAIL timeout_nomsg: %0d pulses fields %h, expected 0 and %h",
               got.size(), cur(), before);
    end
    got.delete();
    rand_words(w);
    test_fixed(w, "after_timeout");
  endtask
`endif

  initial begin
    word_arr_t w;
    test_reset();
    w = '{6'h05, 6'h13, 6'h06, 6'h2A, 6'h04, 6'h01};
    test_fixed(w, "basic");
    vectors++;
    if (cur() !== {4'd5, 5'd19, 3'd6, 6'd42, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL basic_const: got %h", cur());
    end
    w = '{default: 6'h3F};
    test_fixed(w, "upper");
    vectors++;
    if (cur() !== {4'hF, 5'h1F, 3'd7, 6'h3F, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL upper_const: got %h", cur());
    end
    test_random();
    test_back_to_back();
    test_abort();
    test_hold();
`ifdef RECV_TIMEOUT_EN
    test_timeout();
`endif
    vectors++;
    if (err_pulses != exp_err) begin
      errors++;
      $display("FAIL msg_err_count: %0d pulses, expected %0d", err_pulses, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
